// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and elaboration helpers for serial_adder
//
// Purpose : FSM state encoding, counter-width helper and parameter sanity check
//           used by the serial_adder top.
// Ports   : none (package)
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Slice counter width; a single-slice adder still needs one counter bit.
  function automatic int cnt_width(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

  // Operands must split into whole slices and be at least two bits wide.
  function automatic bit split_ok(input int width, input int bpc);
    return (bpc > 0) && (width >= 2) && ((width % bpc) == 0);
  endfunction

endpackage

// File: rtl/fa_cell.sv
// rtl/fa_cell.sv - single-bit combinational full adder
//
// Purpose : one full-adder cell; the serial adder chains several of these
//           ripple-style to form one slice.
// Ports   : a, b  in  operand bits
//           ci    in  carry in
//           s     out sum bit
//           co    out carry out
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - multi-cycle adder processing BITS_PER_CYCLE bits per clock
//
// Purpose : adds a + b + cin, LSB slice first, one slice per RUN cycle, using a
//           ripple chain of fa_cell instances. Start/done handshake.
// Ports   : clk       in   clock, rising edge
//           reset     in   asynchronous active-high reset
//           start     in   request, accepted in IDLE or DONE
//           a, b      in   WIDTH-bit operands, captured on the accepting edge
//           cin       in   carry in, captured on the accepting edge
//           busy      out  high while in RUN
//           done      out  one-cycle pulse in DONE
//           sum       out  WIDTH-bit result, updated only on entry to DONE
//           cout      out  carry out of the MSB
//           overflow  out  signed overflow of the addition
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int N        = WIDTH / BITS_PER_CYCLE;
  localparam int CW       = cnt_width(N);
  localparam int LAST_CNT = N - 1;

  if (!split_ok(WIDTH, BITS_PER_CYCLE)) begin : g_bad_split
    $error("serial_adder: WIDTH must be >= 2 and a multiple of BITS_PER_CYCLE");
  end

  state_t            state;
  state_t            state_next;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  a_sr;
  logic [WIDTH-1:0]  b_sr;
  logic [WIDTH-1:0]  res_sr;
  logic              carry;

  logic              accept;
  logic              last;
  logic              step;

  logic [BITS_PER_CYCLE:0]   chain;
  logic [BITS_PER_CYCLE-1:0] slice_sum;
  logic [WIDTH-1:0]          res_next;

  // Ripple chain for one slice; chain[0] is the carry held between cycles.
  assign chain[0] = carry;

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_slice
    fa_cell u_fa (
      .a  (a_sr[i]),
      .b  (b_sr[i]),
      .ci (chain[i]),
      .s  (slice_sum[i]),
      .co (chain[i+1])
    );
  end

  // Result fills from the MSB side, so after N slices the LSB slice sits at bit 0.
  assign res_next = (res_sr >> BITS_PER_CYCLE)
                  | (WIDTH'(slice_sum) << (WIDTH - BITS_PER_CYCLE));

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (cnt == CW'(LAST_CNT)) begin
          last       = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign step = (state == RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      carry    <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      cnt    <= '0;
      a_sr   <= a;
      b_sr   <= b;
      res_sr <= '0;
      carry  <= cin;
    end else if (step) begin
      a_sr   <= a_sr >> BITS_PER_CYCLE;
      b_sr   <= b_sr >> BITS_PER_CYCLE;
      res_sr <= res_next;
      carry  <= chain[BITS_PER_CYCLE];
      cnt    <= cnt + CW'(1);
      if (last) begin
        // On the final slice the top cell is bit WIDTH-1, so its carry-in is
        // the carry into the MSB.
        cnt      <= '0;
        sum      <= res_next;
        cout     <= chain[BITS_PER_CYCLE];
        overflow <= chain[BITS_PER_CYCLE] ^ chain[BITS_PER_CYCLE-1];
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder (1 and 4 bits per cycle)
module tb_serial_adder;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start1;
  logic         start4;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;

  logic         busy1, done1, cout1, ovf1;
  logic [W-1:0] sum1;
  logic         busy4, done4, cout4, ovf4;
  logic [W-1:0] sum4;

  res_t q1[$];
  res_t q4[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt1 = 0;
  int   done_cnt4 = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W), .BITS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .a(a), .b(b), .cin(cin),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .overflow(ovf1)
  );

  serial_adder #(.WIDTH(W), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .a(a), .b(b), .cin(cin),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .overflow(ovf4)
  );

  always @(negedge clk) begin
    if (done1) done_cnt1++;
    if (done4) done_cnt4++;
  end

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] t;
    res_t       r;
    t      = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    r.sum  = t[W-1:0];
    r.cout = t[W];
    r.ovf  = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
    return r;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input bit sel4, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic c, input bit track);
    a   = x;
    b   = y;
    cin = c;
    if (sel4) start4 = 1'b1;
    else      start1 = 1'b1;
    if (track) begin
      if (sel4) q4.push_back(model(x, y, c));
      else      q1.push_back(model(x, y, c));
    end
    @(negedge clk);
    start1 = 1'b0;
    start4 = 1'b0;
    a      = $urandom;
    b      = $urandom;
    cin    = $urandom_range(0, 1);
  endtask

  task automatic wait_done(input bit sel4, output int cycles, output int busy_cycles);
    cycles      = 0;
    busy_cycles = 0;
    while (((sel4 ? done4 : done1) == 1'b0) && cycles < 64) begin
      if (sel4 ? busy4 : busy1) busy_cycles++;
      @(negedge clk);
      cycles++;
    end
    if (cycles >= 64) cycles = -1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy1, done1, sum1, cout1, ovf1} !== '0) begin
      errors++;
      $display("FAIL reset_dut1: got %h expected 0", {busy1, done1, sum1, cout1, ovf1});
    end
    checks++;
    if ({busy4, done4, sum4, cout4, ovf4} !== '0) begin
      errors++;
      $display("FAIL reset_dut4: got %h expected 0", {busy4, done4, sum4, cout4, ovf4});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int   cyc, bcyc;
    res_t exp, got;
    issue(1'b0, 8'h5A, 8'h3C, 1'b0, 1'b1);
    wait_done(1'b0, cyc, bcyc);
    checks++;
    if (cyc !== 8) begin errors++; $display("FAIL basic_latency: got %0d expected 8", cyc); end
    exp = q1.pop_front();
    got = '{sum1, cout1, ovf1};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL basic_5a_3c: got %h expected %h", got, exp); end
    checks++;
    if (got !== res_t'({8'h96, 1'b0, 1'b1})) begin
      errors++; $display("FAIL basic_5a_3c_const: got %h expected %h", got, {8'h96, 1'b0, 1'b1});
    end
    @(negedge clk);
    checks++;
    if (done1 !== 1'b0) begin errors++; $display("FAIL done_one_cycle: got %b expected 0", done1); end

    issue(1'b0, 8'hFF, 8'h01, 1'b0, 1'b1);
    wait_done(1'b0, cyc, bcyc);
    checks++;
    if (bcyc !== 8) begin errors++; $display("FAIL busy_cycles: got %0d expected 8", bcyc); end
    exp = q1.pop_front();
    got = '{sum1, cout1, ovf1};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL basic_ff_01: got %h expected %h", got, exp); end
    @(negedge clk);
  endtask

  task automatic test_bpc4;
    int   cyc, bcyc;
    res_t exp, got;
    issue(1'b1, 8'h7F, 8'h00, 1'b1, 1'b1);
    wait_done(1'b1, cyc, bcyc);
    checks++;
    if (cyc !== 2) begin errors++; $display("FAIL bpc4_latency: got %0d expected 2", cyc); end
    checks++;
    if (bcyc !== 2) begin errors++; $display("FAIL bpc4_busy: got %0d expected 2", bcyc); end
    exp = q4.pop_front();
    got = '{sum4, cout4, ovf4};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL bpc4_7f_00_1: got %h expected %h", got, exp); end
    @(negedge clk);
  endtask

  task automatic test_ignore_start;
    int   cyc, bcyc, base;
    res_t exp, got;
    base = done_cnt1;
    issue(1'b0, 8'h12, 8'h34, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    a      = 8'hAA;
    b      = 8'hBB;
    cin    = 1'b1;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_done(1'b0, cyc, bcyc);
    checks++;
    if (cyc < 0 || cyc + 4 !== 8) begin
      errors++; $display("FAIL ignore_latency: got %0d expected 8", cyc < 0 ? cyc : cyc + 4);
    end
    exp = q1.pop_front();
    got = '{sum1, cout1, ovf1};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL ignore_result: got %h expected %h", got, exp); end
    repeat (12) @(negedge clk);
    checks++;
    if (done_cnt1 - base !== 1) begin
      errors++; $display("FAIL ignore_done_pulses: got %0d expected 1", done_cnt1 - base);
    end
    checks++;
    if (busy1 !== 1'b0) begin errors++; $display("FAIL ignore_idle: busy got %b expected 0", busy1); end
  endtask

  task automatic test_back_to_back;
    int   cyc, bcyc;
    res_t exp, got;
    issue(1'b0, 8'h10, 8'h20, 1'b0, 1'b1);
    wait_done(1'b0, cyc, bcyc);
    exp = q1.pop_front();
    got = '{sum1, cout1, ovf1};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL b2b_first: got %h expected %h", got, exp); end
    issue(1'b0, 8'h01, 8'h01, 1'b0, 1'b1);
    checks++;
    if ({busy1, done1} !== 2'b10) begin
      errors++; $display("FAIL b2b_rerun: busy,done got %b expected 10", {busy1, done1});
    end
    wait_done(1'b0, cyc, bcyc);
    checks++;
    if (cyc !== 8) begin errors++; $display("FAIL b2b_latency: got %0d expected 8", cyc); end
    exp = q1.pop_front();
    got = '{sum1, cout1, ovf1};
    checks++;
    if (got !== exp || sum1 !== 8'h02) begin
      errors++; $display("FAIL b2b_second: got %h expected %h", got, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    int base;
    issue(1'b0, 8'h33, 8'h44, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busy1, done1, sum1, cout1, ovf1} !== '0) begin
      errors++; $display("FAIL midrun_reset_dut1: got %h expected 0", {busy1, done1, sum1, cout1, ovf1});
    end
    checks++;
    if ({busy4, done4, sum4, cout4, ovf4} !== '0) begin
      errors++; $display("FAIL midrun_reset_dut4: got %h expected 0", {busy4, done4, sum4, cout4, ovf4});
    end
    @(negedge clk);
    reset = 1'b0;
    base  = done_cnt1;
    repeat (12) @(negedge clk);
    checks++;
    if (done_cnt1 !== base || busy1 !== 1'b0) begin
      errors++; $display("FAIL midrun_no_done: pulses got %0d busy %b expected 0 0", done_cnt1 - base, busy1);
    end
  endtask

  task automatic test_random;
    int           cyc, bcyc;
    res_t         exp, got;
    logic [W-1:0] x, y;
    logic         c;
    for (int i = 0; i < 24; i++) begin
      bit sel4;
      sel4 = (i >= 16);
      case (i % 16)
        0:       begin x = 8'h00; y = 8'h00; c = 1'b0; end
        1:       begin x = 8'hFF; y = 8'hFF; c = 1'b1; end
        2:       begin x = 8'h80; y = 8'h80; c = 1'b0; end
        3:       begin x = 8'hFF; y = 8'h00; c = 1'b1; end
        default: begin x = $urandom; y = $urandom; c = $urandom_range(0, 1); end
      endcase
      issue(sel4, x, y, c, 1'b1);
      wait_done(sel4, cyc, bcyc);
      if (sel4) begin
        exp = q4.pop_front();
        got = '{sum4, cout4, ovf4};
      end else begin
        exp = q1.pop_front();
        got = '{sum1, cout1, ovf1};
      end
      checks++;
      if (cyc < 0 || got !== exp) begin
        errors++;
        $display("FAIL random_%0d: a=%h b=%h cin=%b got %h expected %h (cycles %0d)", i, x, y, c, got, exp, cyc);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    reset  = 1'b1;
    start1 = 1'b0;
    start4 = 1'b0;
    a      = '0;
    b      = '0;
    cin    = 1'b0;
    test_reset;
    test_basic;
    test_bpc4;
    test_ignore_start;
    test_back_to_back;
    test_reset_mid_run;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
